// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: frames UART bytes into checksummed register accesses and returns a one-byte response
module uart_cmd_ctrl #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       reg_wr_en,
    output logic       reg_rd_en,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    input  logic       reg_ack,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    output logic       busy,
    output logic [7:0] err_cnt
);
    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, CHK, EXEC, RESP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    cmd_q, addr_q, data_q, cmd_n, addr_n, data_n, tx_data_n;
    logic          wr_n, rd_n, tx_valid_n, err_inc, frame_ok;

    assign frame_ok = (rx_data == (cmd_q ^ addr_q ^ data_q)) && (cmd_q == 8'h01 || cmd_q == 8'h02);

    // next state, byte capture, timeout and error detection
    always_comb begin
        state_n    = state;
        cnt_n      = '0;
        cmd_n      = cmd_q;
        addr_n     = addr_q;
        data_n     = data_q;
        wr_n       = reg_wr_en;
        rd_n       = reg_rd_en;
        tx_valid_n = tx_valid;
        tx_data_n  = tx_data;
        err_inc    = 1'b0;
        case (state)
            IDLE: if (rx_valid && rx_data == 8'hA5) state_n = CMD;
            CMD, ADDR, DATA, CHK: begin
                if (rx_valid) begin
                    case (state)
                        CMD:     begin cmd_n  = rx_data; state_n = ADDR; end
                        ADDR:    begin addr_n = rx_data; state_n = DATA; end
                        DATA:    begin data_n = rx_data; state_n = CHK;  end
                        default: begin
                            state_n    = frame_ok ? EXEC : RESP;
                            wr_n       = frame_ok && cmd_q == 8'h01;
                            rd_n       = frame_ok && cmd_q == 8'h02;
                            tx_valid_n = !frame_ok;
                            tx_data_n  = frame_ok ? tx_data : 8'hEE;
                            err_inc    = !frame_ok;
                        end
                    endcase
                end else if (cnt == CW'(TIMEOUT_CYC - 1)) begin
                    state_n = IDLE;
                    err_inc = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            EXEC: begin
                err_inc = rx_valid;
                if (reg_ack) begin
                    wr_n       = 1'b0;
                    rd_n       = 1'b0;
                    tx_valid_n = 1'b1;
                    tx_data_n  = reg_wr_en ? 8'h55 : reg_rdata;
                    state_n    = RESP;
                end
            end
            RESP: begin
                err_inc = rx_valid;
                if (tx_ready) begin
                    tx_valid_n = 1'b0;
                    state_n    = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state and registered outputs; address/data mirror the latched frame bytes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            reg_wr_en <= 1'b0;
            reg_rd_en <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            busy      <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            cmd_q     <= cmd_n;
            addr_q    <= addr_n;
            data_q    <= data_n;
            reg_wr_en <= wr_n;
            reg_rd_en <= rd_n;
            reg_addr  <= addr_n;
            reg_wdata <= data_n;
            tx_valid  <= tx_valid_n;
            tx_data   <= tx_data_n;
            busy      <= state_n != IDLE;
            err_cnt   <= (err_inc && err_cnt != 8'hFF) ? err_cnt + 8'd1 : err_cnt;
        end
    end
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed checks of framing, access handshake, errors, timeout and reset
module tb_uart_cmd_ctrl;
    localparam int TO = 16;

    logic       clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, reg_ack = 1'b0, tx_ready = 1'b0;
    logic [7:0] rx_data = '0, reg_rdata = '0;
    logic       reg_wr_en, reg_rd_en, tx_valid, busy;
    logic [7:0] reg_addr, reg_wdata, tx_data, err_cnt;
    int errors = 0, checks = 0;
    int wr_total = 0, rd_total = 0, both_total = 0, txv_total = 0;
    int wr_snap, rd_snap, txv_snap;

    uart_cmd_ctrl #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_addr(reg_addr),
        .reg_wdata(reg_wdata), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
        .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // cycle counts of request/response activity, sampled mid-cycle
    always @(negedge clk) begin
        if (reg_wr_en) wr_total++;
        if (reg_rd_en) rd_total++;
        if (reg_wr_en && reg_rd_en) both_total++;
        if (tx_valid) txv_total++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] d, input logic [7:0] k);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(a);
        send_byte(d);
        send_byte(k);
    endtask

    task automatic accept();
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " outs"}, {reg_wr_en, reg_rd_en, tx_valid, busy}, 4'b0000);
        check({tag, " addr/wdata"}, {reg_addr, reg_wdata}, 16'h0000);
        check({tag, " tx_data"}, tx_data, 8'h00);
        check({tag, " err_cnt"}, err_cnt, 8'd0);
    endtask

    initial begin
        tick();
        tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // write frame, ack two cycles after the request rises
        send_byte(8'hA5);
        check("busy after sync", busy, 1'b1);
        send_byte(8'h01);
        send_byte(8'h10);
        send_byte(8'h3C);
        wr_snap = wr_total;
        send_byte(8'h2D);
        check("wr req", {reg_wr_en, reg_rd_en, tx_valid}, 3'b100);
        check("wr addr/wdata", {reg_addr, reg_wdata}, 16'h103C);
        tick();
        reg_ack = 1'b1;
        tick();
        reg_ack = 1'b0;
        check("wr done req low", {reg_wr_en, tx_valid}, 2'b01);
        check("wr resp", tx_data, 8'h55);
        check("wr req cycles", wr_total - wr_snap, 2);
        check("wr err_cnt", err_cnt, 8'd0);
        accept();
        check("wr idle", {tx_valid, busy}, 2'b00);

        // read frame, response held while the transmitter stalls
        wr_snap = wr_total;
        rd_snap = rd_total;
        send_frame(8'h02, 8'h20, 8'h00, 8'h22);
        check("rd req", {reg_wr_en, reg_rd_en}, 2'b01);
        check("rd addr", reg_addr, 8'h20);
        reg_ack   = 1'b1;
        reg_rdata = 8'h7E;
        tick();
        reg_ack   = 1'b0;
        reg_rdata = 8'h00;
        check("rd req dropped", reg_rd_en, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("rd resp held", {tx_valid, tx_data}, 9'h17E);
            tick();
        end
        check("rd resp still held", {tx_valid, tx_data}, 9'h17E);
        accept();
        check("rd idle", {tx_valid, busy}, 2'b00);
        check("rd one access", rd_total - rd_snap, 1);
        check("rd no write", wr_total - wr_snap, 0);

        // bad checksum then bad command
        wr_snap = wr_total;
        rd_snap = rd_total;
        send_frame(8'h01, 8'h10, 8'h3C, 8'h00);
        check("badchk resp", {tx_valid, tx_data}, 9'h1EE);
        check("badchk err", err_cnt, 8'd1);
        accept();
        send_frame(8'h07, 8'h00, 8'h00, 8'h07);
        check("badcmd resp", {tx_valid, tx_data}, 9'h1EE);
        check("badcmd err", err_cnt, 8'd2);
        accept();
        check("bad no req", (wr_total - wr_snap) + (rd_total - rd_snap), 0);

        // timeout with no byte at expiry
        txv_snap = txv_total;
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (TO - 1) tick();
        check("to pending busy", busy, 1'b1);
        tick();
        check("to idle", {busy, tx_valid}, 2'b00);
        check("to err", err_cnt, 8'd3);
        tick();
        check("to no resp", txv_total - txv_snap, 0);

        // byte arriving in the expiry cycle keeps the frame alive
        send_byte(8'hA5);
        send_byte(8'h01);
        repeat (TO - 1) tick();
        send_byte(8'h10);
        check("to race busy", busy, 1'b1);
        check("to race err", err_cnt, 8'd3);
        send_byte(8'h3C);
        send_byte(8'h2D);
        check("to race req", {reg_wr_en, reg_addr, reg_wdata}, 17'h1103C);
        reg_ack = 1'b1;
        tick();
        reg_ack = 1'b0;
        check("to race resp", {tx_valid, tx_data}, 9'h155);
        accept();

        // overrun bytes during an access
        send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        check("ovr req kept", {reg_wr_en, reg_addr, reg_wdata}, 17'h1103C);
        check("ovr err", err_cnt, 8'd6);
        reg_ack = 1'b1;
        tick();
        reg_ack = 1'b0;
        check("ovr resp", {tx_valid, tx_data}, 9'h155);
        accept();
        check("ovr idle", busy, 1'b0);

        // saturation
        for (int i = 0; i < 300; i++) begin
            send_frame(8'h01, 8'h10, 8'h3C, 8'h00);
            accept();
        end
        check("sat err", err_cnt, 8'd255);

        // reset in the middle of a write access
        send_frame(8'h01, 8'h10, 8'h3C, 8'h2D);
        check("mid wr req", reg_wr_en, 1'b1);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("mid reset");
        rst_n = 1'b1;
        send_frame(8'h02, 8'h20, 8'h00, 8'h22);
        check("post rst rd", {reg_wr_en, reg_rd_en, reg_addr}, 10'h120);
        reg_ack   = 1'b1;
        reg_rdata = 8'h3C;
        tick();
        reg_ack = 1'b0;
        check("post rst resp", {tx_valid, tx_data}, 9'h13C);
        accept();
        check("post rst idle", {busy, err_cnt}, 9'h000);
        check("never both req", both_total, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Command sequencer that sits directly behind the UART byte receiver and turns its byte stream into register accesses on the PVT sensor configuration/status bus. It frames incoming bytes, verifies a checksum, issues a single write or read with a request/acknowledge handshake, and returns a one-byte response toward the UART transmitter. Malformed, stalled or overrunning traffic is discarded and counted.

## Interface
- `TIMEOUT_CYC`, default 1024: inter-byte timeout, in clk cycles, while a frame is partially received.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx_valid`  in  1  single-cycle pulse; `rx_data` holds a received byte.
- `rx_data`  in  8  received byte, sampled only when `rx_valid`=1.
- `reg_wr_en`  out  1  write request, held until `reg_ack`.
- `reg_rd_en`  out  1  read request, held until `reg_ack`.
- `reg_addr`  out  8  register address, stable while a request is pending.
- `reg_wdata`  out  8  write data, stable while `reg_wr_en`=1.
- `reg_rdata`  in  8  read data, sampled in the `reg_ack` cycle of a read.
- `reg_ack`  in  1  access complete; ignored when no request is pending.
- `tx_valid`  out  1  response byte available.
- `tx_data`  out  8  response byte, stable while `tx_valid`=1.
- `tx_ready`  in  1  transmitter accepts; transfer when `tx_valid`&&`tx_ready`.
- `busy`  out  1  high in every state except IDLE.
- `err_cnt`  out  8  saturating error counter; stays at 255.

## Operation
- Frame format: SYNC=0xA5, CMD, ADDR, DATA, CHK, where CHK = CMD ^ ADDR ^ DATA. CMD 0x01 = write, 0x02 = read. For a read, DATA is required but ignored.
- States and transitions:
  - IDLE: on `rx_valid` with byte 0xA5, go to CMD. Other bytes are dropped silently, with no error.
  - CMD, ADDR, DATA, CHK: each accepts one byte on `rx_valid` and advances. Bytes are latched into cmd_q, addr_q and data_q.
  - On the CHK byte, the frame is validated in the same cycle:
    - Checksum match and CMD ∈ {0x01, 0x02}: go to EXEC.
    - Otherwise: go to RESP with `tx_data`=0xEE, and increment `err_cnt`.
  - EXEC: `reg_wr_en` or `reg_rd_en` is high, with `reg_addr`=addr_q and `reg_wdata`=data_q. On `reg_ack`:
    - Drop the request.
    - Latch the response: write gives 0x55; read gives `reg_rdata`.
    - Go to RESP.
  - RESP: `tx_valid`=1. On `tx_valid`&&`tx_ready`, go to IDLE.
- Timeout: a cycle counter runs in CMD..CHK and is cleared on every accepted byte.
  - When the counter reaches `TIMEOUT_CYC`-1 with no `rx_valid`: go to IDLE, increment `err_cnt`, send no response.
  - If `rx_valid` occurs in the same cycle, the byte wins and the counter clears.
- Overrun: an `rx_valid` pulse in EXEC or RESP is discarded and increments `err_cnt`. The current transaction is unaffected.
- `err_cnt` increments by at most 1 per cycle and saturates at 255 (no wrap). It is cleared only by reset.
- `reg_wr_en` and `reg_rd_en` are never high together. No new request is issued until the previous response has been transferred.

## Timing
- All outputs are registered. Reset values (when `rst_n`=0 at a clock edge): state IDLE; `reg_wr_en`=0, `reg_rd_en`=0, `reg_addr`=0, `reg_wdata`=0, `tx_valid`=0, `tx_data`=0, `busy`=0, `err_cnt`=0, timeout counter 0.
- Reset mid-frame or mid-access drops the request at the next edge with no response. The register side must tolerate an abandoned request.
- CHK byte accepted at cycle t:
  - Valid frame: request high from t+1.
  - Invalid frame: `tx_valid` high from t+1.
- `reg_ack` at cycle a: request low from a+1, and `tx_valid` high from a+1. Minimum access time is 1 cycle (ack may arrive in cycle t+1).
- Transfer at cycle r: `tx_valid` low and `busy` low from r+1. A SYNC byte at r+1 starts a new frame.
- `busy` rises the cycle after SYNC is accepted.

## Test plan
- Write frame A5 01 10 3C 2D, `reg_ack` 2 cycles after request -> `reg_wr_en` with addr 0x10, wdata 0x3C, for exactly 2 cycles; then `tx_data`=0x55; `err_cnt`=0.
- Read frame A5 02 20 00 22, `reg_rdata`=0x7E at ack -> `reg_rd_en` for one access, `reg_wr_en` never high; `tx_data`=0x7E; hold `tx_ready`=0 for 5 cycles -> `tx_valid` and `tx_data` stable until accepted.
- Bad checksum A5 01 10 3C 00, and bad CMD A5 07 00 00 07 -> no register request; `tx_data`=0xEE each; `err_cnt`=2.
- Timeout: send A5 01, then stall `TIMEOUT_CYC` cycles -> back to IDLE, no `tx_valid`, `err_cnt`=1. Repeat with a byte in the expiry cycle -> frame continues.
- Overrun and saturation: 3 bytes during EXEC -> `err_cnt`+3 and the access completes normally. Then 300 bad frames -> `err_cnt` holds at 255.
- Mid-access reset: `rst_n`=0 while `reg_wr_en`=1 -> all outputs at reset values after the edge; the next valid frame works.
